time_set_counter: RTL and testbench
===================================

Name: time_set_counter

Overview:
- Clocked time-of-day counter with a field-entry front end. Successor to the combinational hours/minutes/seconds entry block.
- Adds four things the entry block lacked:
  - a running counter advanced by a 1 Hz tick;
  - an edit/commit protocol driven by `switch`;
  - range clamping with an error flag;
  - a parametrised hour modulus (12 h or 24 h).
- Sits between board switches/buttons (already synchronised to `clk`) and the display driver.

Parameters:
- HOUR_MAX, 23, largest hour value; the hours field wraps to 0 after it (use 11 for 12 h operation).
- HR_W, 5, hours field width; must satisfy HOUR_MAX < 2**HR_W (elaboration error otherwise).
- VAL_W, 6, width of the entry value bus; must be ≥ 6.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle pulse, once per second.
- mode  in  3  field select: 1=sec, 2=min, 3=hrs; 0 and 7 ignored; 4-6 are alarm fields when the alarm feature is enabled, ignored otherwise.
- switch  in  1  level: 1 = edit, 0 = run.
- wr  in  1  write strobe for val into the field selected by mode.
- val  in  VAL_W  entry value.
- hrs  out  HR_W  displayed hours.
- min  out  6  displayed minutes.
- sec  out  6  displayed seconds.
- editing  out  1  high while in EDIT.
- err  out  1  one-cycle pulse when a write was clamped.
- alarm_hit  out  1  present only with TIME_SET_ALARM_EN.

Behaviour:
- Reset (async, active-high):
  - running counters, staging registers and the switch-delay register go to 0;
  - state goes to RUN;
  - hrs/min/sec/editing/err/alarm_hit go to 0.
  - Reset mid-edit discards staging.
- States: RUN, EDIT. Edges of `switch` are detected against a registered copy `switch_q`.
- RUN:
  - On tick, sec increments. sec 59→0 carries into min; min 59→0 carries into hrs; hrs HOUR_MAX→0. All carries resolve in the same cycle, so 23:59:59 → 00:00:00 in one tick.
  - Outputs show the running counters, registered, one cycle after the tick.
  - wr is ignored.
- RUN→EDIT on rising switch:
  - staging ← running counters; editing=1 from the next cycle.
  - A tick in the same cycle is ignored.
- EDIT:
  - Running counters are frozen; ticks are ignored.
  - Outputs show staging.
  - On wr with mode 1/2/3, the selected staging field ← min(val, limit). Limits are 59 / 59 / HOUR_MAX.
  - Clamping is decided on the full VAL_W compare. hrs takes the low HR_W bits of the clamped value.
  - If val > limit, err=1 for exactly the following cycle.
  - Staging and outputs update one cycle after wr.
  - Back-to-back writes are accepted every cycle.
- EDIT→RUN on falling switch:
  - running ← staging; editing=0 next cycle.
  - A wr in the same cycle is merged into the committed value, with clamping applied.
  - A tick in the commit cycle is dropped; counting resumes on the next tick.
- Rising and falling switch inside one cycle cannot occur, because switch is sampled once per cycle.
- No output is combinational from inputs.

Optional Feature:
- Macro: TIME_SET_ALARM_EN.
- With the macro:
  - Alarm registers (reset 0) are written in EDIT via mode 4=sec, 5=min, 6=hrs, with the same clamping and err rules.
  - alarm_hit pulses for one cycle, one cycle after a tick that makes the running time equal the alarm time.
  - No pulse is produced in EDIT or at commit.
- Without the macro: the alarm_hit port and alarm registers do not exist, and modes 4-6 are ignored with no err.

Decomposition:
- Package time_set_pkg holds:
  - mode encodings MODE_SEC=1, MODE_MIN=2, MODE_HRS=3, MODE_ASEC=4, MODE_AMIN=5, MODE_AHRS=6;
  - SEC_MAX=59 and MIN_MAX=59;
  - the state encoding for RUN/EDIT.
- One sub-module, mod_counter:
  - parameters MAX, W;
  - inputs: inc, load, load_val;
  - outputs: value, carry_out (asserted when inc and value==MAX).
- mod_counter is instantiated three times, chained by carry. Load takes priority over inc.

Test Plan:
- Reset, then 3 ticks → 00:00:03. Assert reset mid-count → all outputs 0 immediately (async).
- switch=1; wr mode=1 val=55, mode=2 val=59, mode=3 val=23; switch=0 → display 23:59:55 with editing=0. Then 5 ticks → 00:00:00.
- In EDIT: wr mode=3 val=30 → hrs=23, err high for one cycle. wr mode=2 val=63 → min=59, err pulse. wr mode=0 val=10 → no change, no err.
- HOUR_MAX=11 instance: commit 11:59:59, one tick → 00:00:00.
- Tick asserted on the same cycle as the falling switch → committed value is unchanged, and the next tick advances sec by exactly 1. Ticks during EDIT → running time unchanged after commit.
- With TIME_SET_ALARM_EN: alarm set to 00:01:00, time committed at 00:00:58, 2 ticks → one alarm_hit pulse on the cycle after the second tick. Without the macro, a mode=4 write has no effect.

Source files
------------

// File: rtl/time_set_pkg.sv
// Shared constants for the time-of-day counter: mode encodings, field limits
// and the RUN/EDIT state encoding.
package time_set_pkg;

   // Field-select encodings carried on the mode input
   localparam logic [2:0] MODE_SEC  = 3'd1;
   localparam logic [2:0] MODE_MIN  = 3'd2;
   localparam logic [2:0] MODE_HRS  = 3'd3;
   localparam logic [2:0] MODE_ASEC = 3'd4;
   localparam logic [2:0] MODE_AMIN = 3'd5;
   localparam logic [2:0] MODE_AHRS = 3'd6;

   // Largest legal seconds / minutes value and their field width
   localparam int unsigned SEC_MAX = 59;
   localparam int unsigned MIN_MAX = 59;
   localparam int unsigned MS_W    = 6;

   typedef enum logic {
      StRun,
      StEdit
   } state_e;

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) counter with synchronous load; load wins over inc.
// carry_out flags the wrap so counters can be chained in one cycle.
module mod_counter #(
   parameter int unsigned MAX = 59,
   parameter int unsigned W   = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] value,
   output logic         carry_out
);

   localparam logic [W-1:0] MaxV = W'(MAX);

   logic [W-1:0] value_q, value_d;

   // Next value: load, else wrap-or-increment, else hold
   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = load_val;
      end else if (inc) begin
         value_d = (value_q == MaxV) ? '0 : value_q + W'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value     = value_q;
   assign carry_out = inc && (value_q == MaxV);

endmodule

// File: rtl/time_set_counter.sv
// Time-of-day counter with an edit/commit front end. In RUN the counters
// advance on tick; a rising switch copies them into staging registers that
// wr edits (clamped, with a one-cycle err pulse); a falling switch commits
// staging back into the counters.
// Optional alarm comparator enabled by defining TIME_SET_ALARM_EN.
module time_set_counter
   import time_set_pkg::*;
#(
   parameter int unsigned HOUR_MAX = 23,
   parameter int unsigned HR_W     = 5,
   parameter int unsigned VAL_W    = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic [2:0]       mode,
   input  logic             switch,
   input  logic             wr,
   input  logic [VAL_W-1:0] val,
   output logic [HR_W-1:0]  hrs,
   output logic [5:0]       min,
   output logic [5:0]       sec,
   output logic             editing,
   output logic             err
`ifdef TIME_SET_ALARM_EN
   ,
   output logic             alarm_hit
`endif
);

   if (HOUR_MAX >= (32'd1 << HR_W)) begin : g_bad_hr_w
      $error("HOUR_MAX does not fit in HR_W bits");
   end
   if (VAL_W < 6) begin : g_bad_val_w
      $error("VAL_W must be at least 6");
   end

   localparam logic [VAL_W-1:0] SecLim = VAL_W'(SEC_MAX);
   localparam logic [VAL_W-1:0] MinLim = VAL_W'(MIN_MAX);
   localparam logic [VAL_W-1:0] HrsLim = VAL_W'(HOUR_MAX);

   state_e            state_q, state_d;
   logic              switch_q;
   logic              rise, fall, in_edit, inc_sec, commit;

   logic [5:0]        run_sec, run_min;
   logic [HR_W-1:0]   run_hrs;
   logic              sec_carry, min_carry, unused_hrs_carry;

   logic [5:0]        stg_sec_q, stg_sec_d, stg_min_q, stg_min_d;
   logic [HR_W-1:0]   stg_hrs_q, stg_hrs_d;

   logic              w_sec, w_min, w_hrs, any_wr, over;
   logic [VAL_W-1:0]  lim, val_c;
   logic              err_q, err_d;

   assign rise    = switch && !switch_q;
   assign fall    = !switch && switch_q;
   assign in_edit = (state_q == StEdit);
   // A tick coinciding with entry into EDIT is dropped
   assign inc_sec = tick && (state_q == StRun) && !rise;
   assign commit  = in_edit && fall;

`ifdef TIME_SET_ALARM_EN
   logic              w_asec, w_amin, w_ahrs;
   logic [5:0]        al_sec_q, al_min_q;
   logic [HR_W-1:0]   al_hrs_q;
   logic [5:0]        sec_nx, min_nx;
   logic [HR_W-1:0]   hrs_nx;
   logic              alarm_hit_q, alarm_hit_d;
`endif

   // Write decode and clamping against the full-width value
   always_comb begin
      w_sec = 1'b0;
      w_min = 1'b0;
      w_hrs = 1'b0;
`ifdef TIME_SET_ALARM_EN
      w_asec = 1'b0;
      w_amin = 1'b0;
      w_ahrs = 1'b0;
`endif
      lim = SecLim;
      if (in_edit && wr) begin
         case (mode)
            MODE_SEC:  begin w_sec = 1'b1; lim = SecLim; end
            MODE_MIN:  begin w_min = 1'b1; lim = MinLim; end
            MODE_HRS:  begin w_hrs = 1'b1; lim = HrsLim; end
`ifdef TIME_SET_ALARM_EN
            MODE_ASEC: begin w_asec = 1'b1; lim = SecLim; end
            MODE_AMIN: begin w_amin = 1'b1; lim = MinLim; end
            MODE_AHRS: begin w_ahrs = 1'b1; lim = HrsLim; end
`endif
            default:   ;
         endcase
      end
`ifdef TIME_SET_ALARM_EN
      any_wr = w_sec || w_min || w_hrs || w_asec || w_amin || w_ahrs;
`else
      any_wr = w_sec || w_min || w_hrs;
`endif
      over  = (val > lim);
      val_c = over ? lim : val;
      err_d = any_wr && over;
   end

   // Staging: snapshot on entry to EDIT, then field writes. Its next value is
   // also the commit value, so a wr in the commit cycle is merged.
   always_comb begin
      stg_sec_d = stg_sec_q;
      stg_min_d = stg_min_q;
      stg_hrs_d = stg_hrs_q;
      if ((state_q == StRun) && rise) begin
         stg_sec_d = run_sec;
         stg_min_d = run_min;
         stg_hrs_d = run_hrs;
      end
      if (w_sec) stg_sec_d = 6'(val_c);
      if (w_min) stg_min_d = 6'(val_c);
      if (w_hrs) stg_hrs_d = HR_W'(val_c);
   end

   // RUN/EDIT next-state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRun:   if (rise) state_d = StEdit;
         StEdit:  if (fall) state_d = StRun;
         default: state_d = StRun;
      endcase
   end

   // State, switch edge detector, staging and err registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StRun;
         switch_q  <= 1'b0;
         stg_sec_q <= '0;
         stg_min_q <= '0;
         stg_hrs_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         switch_q  <= switch;
         stg_sec_q <= stg_sec_d;
         stg_min_q <= stg_min_d;
         stg_hrs_q <= stg_hrs_d;
         err_q     <= err_d;
      end
   end

   mod_counter #(
      .MAX (SEC_MAX),
      .W   (MS_W)
   ) u_sec (
      .clk       (clk),
      .reset     (reset),
      .inc       (inc_sec),
      .load      (commit),
      .load_val  (stg_sec_d),
      .value     (run_sec),
      .carry_out (sec_carry)
   );

   mod_counter #(
      .MAX (MIN_MAX),
      .W   (MS_W)
   ) u_min (
      .clk       (clk),
      .reset     (reset),
      .inc       (sec_carry),
      .load      (commit),
      .load_val  (stg_min_d),
      .value     (run_min),
      .carry_out (min_carry)
   );

   mod_counter #(
      .MAX (HOUR_MAX),
      .W   (HR_W)
   ) u_hrs (
      .clk       (clk),
      .reset     (reset),
      .inc       (min_carry),
      .load      (commit),
      .load_val  (stg_hrs_d),
      .value     (run_hrs),
      .carry_out (unused_hrs_carry)
   );

`ifdef TIME_SET_ALARM_EN
   // Time the counters will hold after this cycle's tick
   always_comb begin
      sec_nx = sec_carry ? 6'd0 : run_sec + 6'd1;
      min_nx = run_min;
      if (sec_carry) min_nx = min_carry ? 6'd0 : run_min + 6'd1;
      hrs_nx = run_hrs;
      if (min_carry) hrs_nx = (run_hrs == HR_W'(HOUR_MAX)) ? '0 : run_hrs + HR_W'(1);
      alarm_hit_d = inc_sec && (sec_nx == al_sec_q) && (min_nx == al_min_q) &&
                    (hrs_nx == al_hrs_q);
   end

   // Alarm time registers and hit pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         al_sec_q    <= '0;
         al_min_q    <= '0;
         al_hrs_q    <= '0;
         alarm_hit_q <= 1'b0;
      end else begin
         if (w_asec) al_sec_q <= 6'(val_c);
         if (w_amin) al_min_q <= 6'(val_c);
         if (w_ahrs) al_hrs_q <= HR_W'(val_c);
         alarm_hit_q <= alarm_hit_d;
      end
   end

   assign alarm_hit = alarm_hit_q;
`endif

   assign editing = in_edit;
   assign err     = err_q;
   assign sec     = in_edit ? stg_sec_q : run_sec;
   assign min     = in_edit ? stg_min_q : run_min;
   assign hrs     = in_edit ? stg_hrs_q : run_hrs;

endmodule

// File: tb/tb_time_set_counter.sv
// Directed bench for time_set_counter: a 24 h instance and a 12 h instance
// share all inputs. Define TIME_SET_ALARM_EN to also cover the alarm.
module tb_time_set_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       tick = 1'b0;
   logic [2:0] mode = 3'd0;
   logic       switch = 1'b0;
   logic       wr = 1'b0;
   logic [5:0] val = 6'd0;

   logic [4:0] hrs;
   logic [5:0] min, sec;
   logic       editing, err;
   logic [3:0] hrs12;
   logic [5:0] min12, sec12;
   logic       editing12, err12;
`ifdef TIME_SET_ALARM_EN
   logic       alarm_hit, alarm_hit12;
`endif

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   time_set_counter #(.HOUR_MAX(23), .HR_W(5), .VAL_W(6)) u_dut (
      .clk(clk), .reset(reset), .tick(tick), .mode(mode), .switch(switch), .wr(wr),
      .val(val), .hrs(hrs), .min(min), .sec(sec), .editing(editing), .err(err)
`ifdef TIME_SET_ALARM_EN
      , .alarm_hit(alarm_hit)
`endif
   );

   time_set_counter #(.HOUR_MAX(11), .HR_W(4), .VAL_W(6)) u_dut12 (
      .clk(clk), .reset(reset), .tick(tick), .mode(mode), .switch(switch), .wr(wr),
      .val(val), .hrs(hrs12), .min(min12), .sec(sec12), .editing(editing12), .err(err12)
`ifdef TIME_SET_ALARM_EN
      , .alarm_hit(alarm_hit12)
`endif
   );

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish, expected finish before 200000");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] hms(input int h, input int m, input int s);
      return 32'(h * 4096 + m * 64 + s);
   endfunction

   function automatic logic [31:0] t24();
      return {15'd0, hrs, min, sec};
   endfunction

   function automatic logic [31:0] t12();
      return {16'd0, hrs12, min12, sec12};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_tick();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
   endtask

   task automatic write(input logic [2:0] m, input logic [5:0] v);
      wr = 1'b1;
      mode = m;
      val = v;
      cyc();
      wr = 1'b0;
      mode = 3'd0;
   endtask

   initial begin
      // Reset
      #1 reset = 1'b1;
      cyc();
      chk("reset_time", t24(), hms(0, 0, 0));
      chk("reset_flags", {30'd0, editing, err}, 32'd0);
      chk("reset_time12", t12(), hms(0, 0, 0));
`ifdef TIME_SET_ALARM_EN
      chk("reset_alarm", {31'd0, alarm_hit}, 32'd0);
`endif
      reset = 1'b0;
      cyc();

      // Three ticks
      do_tick();
      chk("tick1", t24(), hms(0, 0, 1));
      do_tick();
      do_tick();
      chk("tick3", t24(), hms(0, 0, 3));

      // Asynchronous reset mid-count
      reset = 1'b1;
      #2;
      chk("async_reset", t24(), hms(0, 0, 0));
      cyc();
      reset = 1'b0;
      cyc();

      // Edit and commit 23:59:55
      switch = 1'b1;
      cyc();
      chk("enter_edit", {31'd0, editing}, 32'd1);
      write(3'd1, 6'd55);
      chk("wr_sec", t24(), hms(0, 0, 55));
      chk("wr_sec_err", {31'd0, err}, 32'd0);
      write(3'd2, 6'd59);
      write(3'd3, 6'd23);
      chk("staged", t24(), hms(23, 59, 55));
      chk("staged12", t12(), hms(11, 59, 55));
      switch = 1'b0;
      cyc();
      chk("commit", t24(), hms(23, 59, 55));
      chk("commit_edit", {31'd0, editing}, 32'd0);
      for (int i = 0; i < 5; i++) do_tick();
      chk("wrap_day", t24(), hms(0, 0, 0));
      chk("wrap_day12", t12(), hms(0, 0, 0));

      // Tick on the rising-switch cycle is ignored
      switch = 1'b1;
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      chk("rise_tick", t24(), hms(0, 0, 0));

      // Clamping and err
      write(3'd3, 6'd30);
      chk("clamp_hrs", {27'd0, hrs}, 32'd23);
      chk("clamp_hrs_err", {31'd0, err}, 32'd1);
      cyc();
      chk("err_one_cycle", {31'd0, err}, 32'd0);
      write(3'd2, 6'd63);
      chk("clamp_min", {26'd0, min}, 32'd59);
      chk("clamp_min_err", {31'd0, err}, 32'd1);
      write(3'd0, 6'd10);
      chk("mode0", t24(), hms(23, 59, 0));
      chk("mode0_err", {31'd0, err}, 32'd0);
      write(3'd4, 6'd5);
      chk("mode4", t24(), hms(23, 59, 0));
      chk("mode4_err", {31'd0, err}, 32'd0);
      write(3'd1, 6'd59);
      chk("sec_at_limit", {26'd0, sec}, 32'd59);
      chk("sec_at_limit_err", {31'd0, err}, 32'd0);
      write(3'd1, 6'd58);

      // Ticks in EDIT are ignored; tick in the commit cycle is dropped
      do_tick();
      do_tick();
      chk("edit_frozen", t24(), hms(23, 59, 58));
      switch = 1'b0;
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      chk("commit_tick", t24(), hms(23, 59, 58));
      do_tick();
      chk("resume_plus1", t24(), hms(23, 59, 59));
      do_tick();
      chk("resume_wrap", t24(), hms(0, 0, 0));

      // wr in the commit cycle is merged with clamping
      switch = 1'b1;
      cyc();
      switch = 1'b0;
      wr = 1'b1;
      mode = 3'd2;
      val = 6'd61;
      cyc();
      wr = 1'b0;
      mode = 3'd0;
      chk("merge", t24(), hms(0, 59, 0));
      chk("merge_err", {30'd0, editing, err}, 32'd1);
      cyc();
      chk("merge_err_clr", {31'd0, err}, 32'd0);

      // 12 h instance wraps at 11:59:59
      switch = 1'b1;
      cyc();
      write(3'd3, 6'd11);
      write(3'd2, 6'd59);
      write(3'd1, 6'd59);
      switch = 1'b0;
      cyc();
      chk("commit12", t12(), hms(11, 59, 59));
      do_tick();
      chk("wrap12", t12(), hms(0, 0, 0));
      chk("roll24", t24(), hms(12, 0, 0));

`ifdef TIME_SET_ALARM_EN
      // Alarm at 00:01:00, time 00:00:58
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      switch = 1'b1;
      cyc();
      write(3'd6, 6'd0);
      write(3'd5, 6'd1);
      write(3'd4, 6'd0);
      write(3'd1, 6'd58);
      chk("alarm_edit", {31'd0, alarm_hit}, 32'd0);
      switch = 1'b0;
      cyc();
      chk("alarm_commit", {31'd0, alarm_hit}, 32'd0);
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      chk("alarm_t1", {31'd0, alarm_hit}, 32'd0);
      cyc();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      chk("alarm_hit", {31'd0, alarm_hit}, 32'd1);
      chk("alarm_time", t24(), hms(0, 1, 0));
      cyc();
      chk("alarm_pulse", {31'd0, alarm_hit}, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
